// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: decoder op codes,
// FSM state encoding and operand-signedness helpers.
package muldiv_pkg;

    // Must stay identical to the decoder's control codes.
    localparam logic [4:0] OP_MUL    = 5'h0A;
    localparam logic [4:0] OP_MULH   = 5'h0B;
    localparam logic [4:0] OP_MULHSU = 5'h0C;
    localparam logic [4:0] OP_MULHU  = 5'h0D;
    localparam logic [4:0] OP_DIV    = 5'h0E;
    localparam logic [4:0] OP_DIVU   = 5'h0F;
    localparam logic [4:0] OP_REM    = 5'h10;
    localparam logic [4:0] OP_REMU   = 5'h11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_CALC = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    function automatic logic is_muldiv_op(input logic [4:0] op);
        return (op >= OP_MUL) && (op <= OP_REMU);
    endfunction

    function automatic logic is_mul_op(input logic [4:0] op);
        return (op >= OP_MUL) && (op <= OP_MULHU);
    endfunction

    function automatic logic is_signed_a(input logic [4:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(input logic [4:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage request/response bundle for the multiply/divide unit.
// master = execute stage, slave = muldiv_sequencer.
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [4:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [4:0]      rd_in;
    logic            flush;
    logic            ready;
    logic            stall;
    logic            result_valid;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;

    modport master (
        output start, op, rs1, rs2, rd_in, flush,
        input  ready, stall, result_valid, result, rd_out
    );

    modport slave (
        input  start, op, rs1, rs2, rd_in, flush,
        output ready, stall, result_valid, result, rd_out
    );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of the magnitude datapath.
// Multiply: {acc, q} is the product register, q starts as the multiplier and
//           m is the multiplicand; one shift-add step per call.
// Divide:   {acc, q} is remainder:dividend, m is the (non-zero) divisor; one
//           restoring step per call, quotient bits shift into q.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] acc,
    input  logic [XLEN-1:0] q,
    input  logic [XLEN-1:0] m,
    output logic [XLEN-1:0] acc_n,
    output logic [XLEN-1:0] q_n
);
    logic [XLEN:0] sum;
    logic [XLEN:0] diff;

    // Single shift-add or restore step; diff MSB set means the trial subtract borrowed.
    always_comb begin
        sum  = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
        diff = {acc, q[XLEN-1]} - {1'b0, m};
        if (is_div) begin
            if (!diff[XLEN]) begin
                acc_n = diff[XLEN-1:0];
                q_n   = {q[XLEN-2:0], 1'b1};
            end else begin
                acc_n = {acc[XLEN-2:0], q[XLEN-1]};
                q_n   = {q[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_n = sum[XLEN:1];
            q_n   = {sum[0], q[XLEN-1:1]};
        end
    end
endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle multiply/divide controller: FSM, iteration counter, sign
// handling and output registers around the muldiv_step datapath.
// Optional: define MULDIV_FASTMUL_EN to do multiplies with one combinational
// multiply in PREP (PREP->FIX, 2-cycle latency); divides stay iterative.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic    clk,
    input  logic    rst_n,
    muldiv_if.slave bus
);
    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN-1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [4:0]        op_q, op_d;
    logic [4:0]        rd_q, rd_d;
    logic [4:0]        rd_out_q, rd_out_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]   qr_q, qr_d;
    logic [XLEN-1:0]   m_q, m_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              neg_q, neg_d;

    logic              accept;
    logic              sign_a, sign_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN-1:0]   step_acc, step_q;
    logic [2*XLEN-1:0] full, prod;

    assign accept = bus.start && is_muldiv_op(bus.op);

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div (~is_mul_op(op_q)),
        .acc    (acc_q),
        .q      (qr_q),
        .m      (m_q),
        .acc_n  (step_acc),
        .q_n    (step_q)
    );

`ifdef MULDIV_FASTMUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
`endif

    // Next-state, datapath update and output selection for the sequencer FSM.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        rd_d     = rd_q;
        rd_out_d = rd_out_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        qr_d     = qr_q;
        m_d      = m_q;
        result_d = result_q;
        neg_d    = neg_q;

        sign_a = is_signed_a(op_q) && a_q[XLEN-1];
        sign_b = is_signed_b(op_q) && b_q[XLEN-1];
        mag_a  = sign_a ? -a_q : a_q;
        mag_b  = sign_b ? -b_q : b_q;
        full   = {acc_q, qr_q};
        prod   = neg_q ? -full : full;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d    = bus.op;
                    a_d     = bus.rs1;
                    b_d     = bus.rs2;
                    rd_d    = bus.rd_in;
                    state_d = ST_PREP;
                end
            end
            ST_PREP: begin
                acc_d = '0;
                cnt_d = '0;
                qr_d  = mag_a;
                m_d   = mag_b;
                // Remainder takes the dividend's sign; everything else takes A xor B.
                neg_d = ((op_q == OP_REM) || (op_q == OP_REMU)) ? sign_a : (sign_a ^ sign_b);
                if (!is_mul_op(op_q) && (b_q == '0)) begin
                    result_d = ((op_q == OP_REM) || (op_q == OP_REMU)) ? a_q : '1;
                    rd_out_d = rd_q;
                    state_d  = ST_DONE;
                end else if (((op_q == OP_DIV) || (op_q == OP_REM)) &&
                             (a_q == MIN_NEG) && (b_q == '1)) begin
                    result_d = (op_q == OP_DIV) ? MIN_NEG : '0;
                    rd_out_d = rd_q;
                    state_d  = ST_DONE;
                end else begin
`ifdef MULDIV_FASTMUL_EN
                    if (is_mul_op(op_q)) begin
                        {acc_d, qr_d} = fast_prod;
                        state_d       = ST_FIX;
                    end else begin
                        state_d = ST_CALC;
                    end
`else
                    state_d = ST_CALC;
`endif
                end
            end
            ST_CALC: begin
                acc_d = step_acc;
                qr_d  = step_q;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                unique case (op_q)
                    OP_MUL:                       result_d = prod[XLEN-1:0];
                    OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod[2*XLEN-1:XLEN];
                    OP_DIV, OP_DIVU:              result_d = neg_q ? -qr_q : qr_q;
                    OP_REM, OP_REMU:              result_d = neg_q ? -acc_q : acc_q;
                    default:                      result_d = result_q;
                endcase
                rd_out_d = rd_q;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A flush kills anything in flight and leaves the visible result untouched.
        if (bus.flush && (state_q != ST_IDLE)) begin
            state_d  = ST_IDLE;
            result_d = result_q;
            rd_out_d = rd_out_q;
        end
        if (bus.flush && (state_q == ST_IDLE)) begin
            state_d = ST_IDLE;
            op_d    = op_q;
            a_d     = a_q;
            b_d     = b_q;
            rd_d    = rd_q;
        end
    end

    // State, datapath and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            rd_out_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            qr_q     <= '0;
            m_q      <= '0;
            result_q <= '0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            rd_out_q <= rd_out_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            qr_q     <= qr_d;
            m_q      <= m_d;
            result_q <= result_d;
            neg_q    <= neg_d;
        end
    end

    assign bus.ready        = (state_q == ST_IDLE);
    assign bus.stall        = (state_q == ST_PREP) || (state_q == ST_CALC) || (state_q == ST_FIX) ||
                              ((state_q == ST_IDLE) && accept);
    assign bus.result_valid = (state_q == ST_DONE) && !bus.flush;
    assign bus.result       = result_q;
    assign bus.rd_out       = rd_out_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: scoreboard of expected results
// pushed at issue time and popped when result_valid strobes.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam int XLEN = 32;
`ifdef MULDIV_FASTMUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = XLEN + 2;
`endif
    localparam int DIV_LAT = XLEN + 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_if #(.XLEN(XLEN)) bus ();

    muldiv_sequencer #(.XLEN(XLEN), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          lat;
    } exp_t;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] res;
    } vec_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_res = '0;

    // Behavioural reference using native signed/unsigned arithmetic.
    function automatic logic [31:0] ref_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] pa, pb, ps;
        logic [63:0]        pu;
        logic signed [31:0] sa, sb;
        logic               ovf;
        pa  = {{32{a[31]}}, a};
        pb  = {{32{b[31]}}, b};
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        ps  = '0;
        pu  = '0;
        ref_model = '0;
        case (op)
            OP_MUL:    begin pu = {32'b0, a} * {32'b0, b}; ref_model = pu[31:0]; end
            OP_MULH:   begin ps = pa * pb; ref_model = ps[63:32]; end
            OP_MULHSU: begin ps = pa * $signed({32'b0, b}); ref_model = ps[63:32]; end
            OP_MULHU:  begin pu = {32'b0, a} * {32'b0, b}; ref_model = pu[63:32]; end
            OP_DIV:    ref_model = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
            OP_DIVU:   ref_model = (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REM:    ref_model = (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
            OP_REMU:   ref_model = (b == 0) ? a : a % b;
            default:   ref_model = '0;
        endcase
    endfunction

    function automatic int exp_latency(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op <= OP_MULHU) return MUL_LAT;
        if (b == 0) return 1;
        if (((op == OP_DIV) || (op == OP_REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
        return DIV_LAT;
    endfunction

    // Present one request for one cycle; returns at the negedge after the accepting edge.
    task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        bus.start = 1'b1;
        bus.op    = op;
        bus.rs1   = a;
        bus.rs2   = b;
        bus.rd_in = rd;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Wait (bounded) for the result strobe and report what was seen.
    task automatic collect(input int budget, output logic [31:0] res, output logic [4:0] rd,
                           output int lat, output bit timeout, output bit one_shot);
        lat = 0;
        while ((bus.result_valid !== 1'b1) && (lat < budget)) begin
            @(negedge clk);
            lat++;
        end
        timeout = (bus.result_valid !== 1'b1);
        res     = bus.result;
        rd      = bus.rd_out;
        @(negedge clk);
        one_shot = (bus.result_valid === 1'b0);
    endtask

    task automatic test_reset();
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus.ready); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", bus.stall); end
        checks++; if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.result_valid); end
        checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL reset_result got %h exp 0", bus.result); end
        checks++; if (bus.rd_out !== 5'h0) begin errors++; $display("FAIL reset_rd_out got %h exp 0", bus.rd_out); end
    endtask

    task automatic test_mul_basic();
        int  lat;
        bit  stall_bad;
        exp_t e;
        sb_q.push_back('{32'd42, 5'd5, MUL_LAT});
        bus.start = 1'b1; bus.op = OP_MUL; bus.rs1 = 32'd7; bus.rs2 = 32'd6; bus.rd_in = 5'd5;
        #1;
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL mul_accept_stall got %b exp 1", bus.stall); end
        @(negedge clk);
        bus.start = 1'b0;
        lat = 0;
        stall_bad = 1'b0;
        while ((bus.result_valid !== 1'b1) && (lat < 100)) begin
            if ((bus.stall !== 1'b1) || (bus.ready !== 1'b0)) stall_bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        e = sb_q.pop_front();
        checks++; if (stall_bad) begin errors++; $display("FAIL mul_busy_stall got dropped exp held"); end
        checks++; if (lat != e.lat) begin errors++; $display("FAIL mul_latency got %0d exp %0d", lat, e.lat); end
        checks++; if (bus.result !== e.res) begin errors++; $display("FAIL mul_result got %h exp %h", bus.result, e.res); end
        checks++; if (bus.rd_out !== e.rd) begin errors++; $display("FAIL mul_rd_out got %0d exp %0d", bus.rd_out, e.rd); end
        @(negedge clk);
        checks++; if ((bus.result_valid !== 1'b0) || (bus.ready !== 1'b1)) begin
            errors++; $display("FAIL mul_after_done valid %b ready %b exp 0 1", bus.result_valid, bus.ready);
        end
        repeat (3) @(negedge clk);
        checks++; if (bus.result !== 32'd42) begin errors++; $display("FAIL mul_result_hold got %h exp 2a", bus.result); end
        last_res = 32'd42;
    endtask

    // Runs a table of vectors through the scoreboard.
    task automatic test_ops(input string name, input vec_t tbl[]);
        logic [31:0] r;
        logic [4:0]  d;
        int          l;
        bit          to, os;
        exp_t        e;
        foreach (tbl[i]) begin
            sb_q.push_back('{tbl[i].res, tbl[i].rd, exp_latency(tbl[i].op, tbl[i].a, tbl[i].b)});
            send(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].rd);
            collect(100, r, d, l, to, os);
            e = sb_q.pop_front();
            checks++; if (to || (r !== e.res)) begin errors++; $display("FAIL %s[%0d] result got %h exp %h timeout %b", name, i, r, e.res, to); end
            checks++; if (d !== e.rd) begin errors++; $display("FAIL %s[%0d] rd_out got %0d exp %0d", name, i, d, e.rd); end
            checks++; if (l != e.lat) begin errors++; $display("FAIL %s[%0d] latency got %0d exp %0d", name, i, l, e.lat); end
            checks++; if (!os) begin errors++; $display("FAIL %s[%0d] valid_width got >1 cycle exp 1", name, i); end
            last_res = r;
        end
    endtask

    task automatic test_multiply();
        vec_t tbl[] = '{
            '{OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0000_0000},
            '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE},
            '{OP_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 5'd3, 32'hFFFF_FFFF},
            '{OP_MUL,    32'hFFFF_FFFD, 32'h0000_0005, 5'd4, 32'hFFFF_FFF1}
        };
        test_ops("mul", tbl);
    endtask

    task automatic test_divide();
        vec_t tbl[] = '{
            '{OP_DIV,  32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFD},
            '{OP_REM,  32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFF},
            '{OP_DIVU, 32'd100,       32'd7,         5'd8,  32'd14},
            '{OP_REMU, 32'd100,       32'd7,         5'd9,  32'd2},
            '{OP_DIV,  32'd7,         32'hFFFF_FFFE, 5'd10, 32'hFFFF_FFFD},
            '{OP_REM,  32'd7,         32'hFFFF_FFFE, 5'd11, 32'd1}
        };
        test_ops("div", tbl);
    endtask

    task automatic test_corner_cases();
        vec_t tbl[] = '{
            '{OP_DIVU, 32'd5,         32'd0,         5'd12, 32'hFFFF_FFFF},
            '{OP_REM,  32'd5,         32'd0,         5'd13, 32'd5},
            '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000},
            '{OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h0},
            '{OP_DIV,  32'hFFFF_FFF0, 32'd0,         5'd16, 32'hFFFF_FFFF},
            '{OP_REMU, 32'h1234_5678, 32'd0,         5'd17, 32'h1234_5678}
        };
        test_ops("corner", tbl);
    endtask

    task automatic test_random();
        vec_t tbl[];
        tbl = new[10];
        foreach (tbl[i]) begin
            tbl[i].op  = 5'($urandom_range(10, 17));
            tbl[i].a   = (i % 3 == 0) ? 32'($urandom_range(0, 1000)) : $urandom;
            tbl[i].b   = (i == 4) ? 32'h0 : (i % 2 == 0) ? 32'($urandom_range(1, 50)) : $urandom;
            tbl[i].rd  = 5'($urandom_range(1, 31));
            tbl[i].res = ref_model(tbl[i].op, tbl[i].a, tbl[i].b);
        end
        test_ops("rand", tbl);
    endtask

    task automatic test_flush();
        bit          seen;
        logic [31:0] r;
        logic [4:0]  d;
        int          l;
        bit          to, os;
        exp_t        e;
        send(OP_DIVU, 32'hDEAD_BEEF, 32'd3, 5'd20);
        repeat (11) @(negedge clk);
        bus.flush = 1'b1;
        #1;
        checks++; if (bus.result_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", bus.result_valid); end
        @(negedge clk);
        bus.flush = 1'b0;
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b exp 1", bus.ready); end
        checks++; if (bus.result !== last_res) begin errors++; $display("FAIL flush_result got %h exp %h", bus.result, last_res); end
        seen = 1'b0;
        repeat (40) begin @(negedge clk); if (bus.result_valid === 1'b1) seen = 1'b1; end
        checks++; if (seen) begin errors++; $display("FAIL flush_no_result got strobe exp none"); end
        // Accept and flush in the same cycle: nothing is taken.
        bus.flush = 1'b1;
        send(OP_DIV, 32'd9, 32'd3, 5'd21);
        bus.flush = 1'b0;
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL flush_accept_ready got %b exp 1", bus.ready); end
        seen = 1'b0;
        repeat (40) begin @(negedge clk); if (bus.result_valid === 1'b1) seen = 1'b1; end
        checks++; if (seen) begin errors++; $display("FAIL flush_accept_result got strobe exp none"); end
        sb_q.push_back('{32'd9, 5'd22, MUL_LAT});
        send(OP_MUL, 32'd3, 32'd3, 5'd22);
        collect(100, r, d, l, to, os);
        e = sb_q.pop_front();
        checks++; if (to || (r !== e.res)) begin errors++; $display("FAIL post_flush_mul got %h exp %h timeout %b", r, e.res, to); end
        checks++; if (d !== e.rd) begin errors++; $display("FAIL post_flush_rd got %0d exp %0d", d, e.rd); end
        last_res = r;
    endtask

    task automatic test_busy_ignore();
        bit          seen;
        logic [31:0] r;
        logic [4:0]  d;
        int          l;
        bit          to, os;
        exp_t        e;
        sb_q.push_back('{32'd14, 5'd3, DIV_LAT - 6});
        send(OP_DIVU, 32'd100, 32'd7, 5'd3);
        repeat (5) @(negedge clk);
        send(OP_MUL, 32'd1, 32'd1, 5'd17);
        collect(100, r, d, l, to, os);
        e = sb_q.pop_front();
        checks++; if (to || (r !== e.res)) begin errors++; $display("FAIL busy_result got %h exp %h timeout %b", r, e.res, to); end
        checks++; if (d !== e.rd) begin errors++; $display("FAIL busy_rd_out got %0d exp %0d", d, e.rd); end
        checks++; if (l != e.lat) begin errors++; $display("FAIL busy_latency got %0d exp %0d", l, e.lat); end
        seen = 1'b0;
        repeat (40) begin @(negedge clk); if (bus.result_valid === 1'b1) seen = 1'b1; end
        checks++; if (seen) begin errors++; $display("FAIL busy_second_result got strobe exp none"); end
        last_res = r;
    endtask

    task automatic test_invalid_op();
        bit seen;
        bus.start = 1'b1; bus.op = 5'h05; bus.rs1 = 32'd4; bus.rs2 = 32'd4; bus.rd_in = 5'd9;
        #1;
        checks++; if ((bus.stall !== 1'b0) || (bus.ready !== 1'b1)) begin
            errors++; $display("FAIL invalid_op_comb stall %b ready %b exp 0 1", bus.stall, bus.ready);
        end
        @(negedge clk);
        bus.start = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            if ((bus.ready !== 1'b1) || (bus.stall !== 1'b0) || (bus.result_valid !== 1'b0)) seen = 1'b1;
            @(negedge clk);
        end
        checks++; if (seen) begin errors++; $display("FAIL invalid_op_idle got activity exp idle"); end
    endtask

    task automatic test_async_reset();
        send(OP_DIVU, 32'hFFFF_0000, 32'd5, 5'd30);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL async_reset_ready got %b exp 1", bus.ready); end
        checks++; if ((bus.result !== 32'h0) || (bus.rd_out !== 5'h0)) begin
            errors++; $display("FAIL async_reset_outputs result %h rd %0d exp 0 0", bus.result, bus.rd_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = '0;
        bus.rs1   = '0;
        bus.rs2   = '0;
        bus.rd_in = '0;
        bus.flush = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_mul_basic();
        test_multiply();
        test_divide();
        test_corner_cases();
        test_flush();
        test_busy_ignore();
        test_invalid_op();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multi-cycle execution unit and controller for the RV32M operations, selected by the decoder's 5-bit control codes 0x0A–0x11.
- Accepts one operation at a time from the execute stage and stalls the pipeline while it is busy.
- Sequences an iterative shift-add multiplier and a restoring divider, applies RISC-V sign and corner-case rules, and returns the result with its destination register tag.

Parameters:
- XLEN, 32: operand and result width.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request from execute stage, qualified by op.
- op  in  5  decoder control code: 0x0A MUL, 0x0B MULH, 0x0C MULHSU, 0x0D MULHU, 0x0E DIV, 0x0F DIVU, 0x10 REM, 0x11 REMU.
- rs1  in  XLEN  operand A (multiplicand / dividend).
- rs2  in  XLEN  operand B (multiplier / divisor).
- rd_in  in  5  destination register tag.
- flush  in  1  kill the in-flight operation.
- ready  out  1  unit idle; start will be accepted.
- stall  out  1  hold the pipeline.
- result_valid  out  1  one-cycle result strobe.
- result  out  XLEN  result data.
- rd_out  out  5  latched destination tag.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; result, rd_out and all internal registers are 0; result_valid 0, stall 0, ready 1.
- Accept: on a rising edge with state IDLE, start=1 and op in 0x0A..0x11, latch op, rs1, rs2 and rd_in; next state PREP.
  - A start with op outside 0x0A..0x11 is ignored.
  - A start while not IDLE is ignored.
- ready = (state==IDLE).
- stall = (state in PREP, CALC, FIX) OR (state==IDLE AND start AND op valid). stall is combinational so the requesting instruction holds in the same cycle.
- FSM states and transitions:
  - IDLE: waits for an accepted start, then goes to PREP.
  - PREP (1 cycle): take the absolute value of each operand that is signed per the op (MULH: both; MULHSU: rs1 only; DIV/REM: both). Record the result sign. Clear the accumulator; counter = 0.
    - Divide by zero: go to DONE. Result is all-ones for DIV/DIVU, rs1 for REM/REMU.
    - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF, DIV/REM): go to DONE. Result is 0x80000000 for DIV, 0 for REM.
    - Otherwise go to CALC.
  - CALC (XLEN cycles, counter 0..XLEN-1):
    - Multiply: one shift-add step per cycle into a 2*XLEN product.
    - Divide: one restore step per cycle.
    - At counter == XLEN-1, go to FIX.
  - FIX (1 cycle): negate where the sign requires.
    - Product sign = sign A XOR sign B.
    - Quotient sign = sign A XOR sign B.
    - Remainder sign = dividend sign.
    - Select the output: MUL takes low XLEN bits; MULH/MULHSU/MULHU take high XLEN bits; DIV/DIVU take the quotient; REM/REMU take the remainder.
    - Register the selected value into result. Go to DONE.
  - DONE (1 cycle): result_valid = NOT flush; rd_out is held; go to IDLE.
- Latency from the accepting edge to result_valid:
  - Normal path: XLEN+2 cycles (34 at default).
  - Corner cases: 1 cycle.
- result and rd_out hold their values until the next DONE.
- flush:
  - In any non-IDLE state, next state is IDLE; no result_valid; result is unchanged.
  - flush in the same cycle as an accept: flush wins and nothing is accepted.
  - flush while IDLE has no effect.
- All arithmetic is unsigned on magnitudes; the counter never wraps because CALC exits at XLEN-1.

Optional Feature:
- Macro MULDIV_FASTMUL_EN.
- Defined: multiply ops use a single combinational XLEN×XLEN multiply in PREP and go PREP→FIX, skipping CALC. Multiply latency is 2 cycles; divide is unchanged.
- Undefined: all ops use the iterative path exactly as described above.

Decomposition:
- Package muldiv_pkg holds:
  - The op-code localparams (0x0A..0x11), kept identical to the decoder's control codes.
  - The FSM state encoding (IDLE, PREP, CALC, FIX, DONE).
  - The helper functions is_signed_a and is_signed_b.
- One sub-module, muldiv_step: combinational single-iteration datapath (one shift-add or one restore step).
- muldiv_sequencer owns the FSM, the counter, the sign logic and the output registers.

Test Plan:
- MUL rs1=7, rs2=6, rd_in=5 → stall high until DONE; result_valid exactly 34 cycles after accept; result=42; rd_out=5.
- MULH rs1=rs2=0xFFFFFFFF → 0x00000000. MULHU with the same operands → 0xFFFFFFFE. MULHSU rs1=0xFFFFFFFF, rs2=2 → 0xFFFFFFFF.
- DIV rs1=-7, rs2=2 → 0xFFFFFFFD (-3). REM with the same operands → 0xFFFFFFFF (-1). DIVU 100/7 → 14. REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000. Each has result_valid 1 cycle after accept.
- Flush at CALC counter=10 → no result_valid, ready=1 next cycle. A new MUL 3*3 started right after → 9.
- start while busy with a different rd_in → ignored; the original result and tag are returned. start with op=0x05 in IDLE → ready stays 1, stall stays 0.
